seven_segment_scanner: RTL
==========================

// Module: seven_segment_scanner
// PURPOSE
//  Time-multiplexed controller for a common-enable, multi-digit seven-segment display.
//  Shares one seven_segment nibble decoder across NUM_DIGITS digits and scans them in turn.
//  New display contents arrive through a valid/ready load port.
//  Loads commit only at a frame boundary, so a frame never shows a mix of old and new digits.
//  Sits between the console status/debug logic and the board's segment/digit-enable pins.
// PARAMETERS
//  NUM_DIGITS    4   number of digits scanned; digit 0 least significant (2..8)
//  DIGIT_CYCLES  3   clk cycles each digit is enabled (>=1)
//  BLANK_CYCLES  1   clk cycles of all-off between digits (anti-ghosting; 0 = none)
// PORTS
//  clk          in   1              system clock
//  reset        in   1              asynchronous, active-high reset
//  load_valid   in   1              load request
//  load_ready   out  1              load port can accept
//  load_data    in   4*NUM_DIGITS   nibble per digit; [3:0] = digit 0
//  load_blank   in   NUM_DIGITS     1 = force digit dark
//  load_dp      in   NUM_DIGITS     decimal point per digit
//  load_lzs     in   1              leading-zero suppression enable
//  seg          out  7              active-high segments, bit0 = A ... bit6 = G
//  dp           out  1              active-high decimal point
//  dig_en       out  NUM_DIGITS     one-hot active-high digit enable, or all zero
//  frame_start  out  1              1-cycle pulse when a new frame's first digit is entered
// BEHAVIOUR
//  Reset (async, immediate)
//   - Outputs: seg=0, dp=0, dig_en=0, frame_start=0, load_ready=1.
//   - Internal: pending cleared; display register blank mask all ones; digit index 0; state S_BLANK.
//  FSM
//   - States: S_BLANK, S_DRIVE.
//   - S_BLANK lasts BLANK_CYCLES (skipped entirely when 0), then goes to S_DRIVE.
//   - S_DRIVE lasts DIGIT_CYCLES, then the index increments and the FSM returns to S_BLANK.
//   - Index wraps from NUM_DIGITS-1 to 0.
//  Outputs
//   - All outputs are registered.
//   - dig_en[idx] is high for exactly DIGIT_CYCLES consecutive cycles, then all-zero for BLANK_CYCLES.
//   - seg and dp are valid whenever dig_en != 0, and are 0 otherwise.
//   - Frame period = NUM_DIGITS*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
//  Frame boundary
//   - Occurs on the wrap transition (idx NUM_DIGITS-1 -> 0).
//   - frame_start pulses in the first cycle of the new frame, including the first frame after reset.
//  Load handshake
//   - Accepted on the clk edge where load_valid & load_ready.
//   - Payload is captured into a pending register; load_ready drops the next cycle.
//   - On the next frame boundary, pending is copied to the display register, pending clears,
//     and load_ready=1 again.
//   - Accept on the same edge as a frame boundary: not committed until the following boundary.
//   - load_valid while load_ready=0 is ignored; payload is not sampled.
//  Digit content
//   - If blank[i]: seg=0, dp=0, and dig_en still asserted for timing uniformity.
//   - Else: seg = decode(nibble[i]), dp = dp[i].
//  Leading-zero suppression
//   - Applies when lzs=1.
//   - Digit i (i>0) is blanked if it and every higher digit are 4'h0.
//   - Digit 0 is never suppressed by LZS.
//   - dp[i]=1 on a digit exempts that digit from suppression.
//  Reset mid-frame: outputs go dark immediately; any pending load is discarded.
// STRUCTURE
//  Package seven_segment_pkg
//   - typedef enum logic {S_BLANK, S_DRIVE} scan_state_e
//   - localparam logic [6:0] SEG_OFF = 7'b000_0000
//  Sub-module: one seven_segment decoder instance, fed by the muxed nibble of the current digit.
//  Counter widths: $clog2 of max(DIGIT_CYCLES, BLANK_CYCLES, 2) and of NUM_DIGITS.
// TESTING (NUM_DIGITS=4, DIGIT_CYCLES=3, BLANK_CYCLES=1)
//  - Reset held 5 cycles -> seg=0, dp=0, dig_en=0, load_ready=1.
//    After release: frame period 16 cycles, dig_en sequence 0,1,1,1,0,2,2,2,...; seg=0 throughout.
//  - Load 16'h12AF, blank=0, lzs=0 -> next frame shows:
//    digit0 7'b111_0001, digit1 7'b111_0111, digit2 7'b101_1011, digit3 7'b000_0110.
//  - Load 16'h0070, lzs=1, dp=0 -> digits 3,2 seg=0; digit1 7'b000_0111; digit0 7'b011_1111.
//    Same load with dp=4'b0100 -> digit2 shows 7'b011_1111 with dp=1.
//  - Second load_valid while pending -> load_ready=0, no capture.
//    load_ready returns to 1 the cycle after frame_start; old frame contents unchanged until then.
//  - Accept on a frame-boundary edge -> the frame now starting still shows old data;
//    the frame after shows new data.
//  - Assert reset during digit 2 with a load pending -> dig_en=0 and seg=0 in the same cycle.
//    After release: display all blank, load_ready=1.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seven_segment_pkg;

  // Scan FSM: dark gap between digits, then the digit is driven.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'b000_0000;

  // Width of the shared dwell counter: wide enough for the longer of the
  // drive and blank phases, and never narrower than one bit.
  function automatic int scan_cnt_width(input int digit_cycles, input int blank_cycles);
    int m;
    m = 2;
    m = (digit_cycles > m) ? digit_cycles : m;
    m = (blank_cycles > m) ? blank_cycles : m;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Load port of the scanner: one valid/ready transfer carries a complete
// display image (nibbles, blank mask, decimal points, zero suppression).
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   load_data;
  logic [NUM_DIGITS-1:0]     load_blank;
  logic [NUM_DIGITS-1:0]     load_dp;
  logic                      load_lzs;

  // Producer of display images (status/debug logic).
  modport master (
    output load_valid,
    output load_data,
    output load_blank,
    output load_dp,
    output load_lzs,
    input  load_ready
  );

  // The scanner itself.
  modport slave (
    input  load_valid,
    input  load_data,
    input  load_blank,
    input  load_dp,
    input  load_lzs,
    output load_ready
  );

endinterface

// File: rtl/seven_segment_scanner_decoder.sv
// Hex nibble to seven-segment pattern, active high, bit0 = A ... bit6 = G.
module seven_segment_scanner_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Combinational glyph table for 0-9, A, b, C, d, E, F.
  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0:    seg_o = 7'b011_1111;
      4'h1:    seg_o = 7'b000_0110;
      4'h2:    seg_o = 7'b101_1011;
      4'h3:    seg_o = 7'b100_1111;
      4'h4:    seg_o = 7'b110_0110;
      4'h5:    seg_o = 7'b110_1101;
      4'h6:    seg_o = 7'b111_1101;
      4'h7:    seg_o = 7'b000_0111;
      4'h8:    seg_o = 7'b111_1111;
      4'h9:    seg_o = 7'b110_1111;
      4'hA:    seg_o = 7'b111_0111;
      4'hB:    seg_o = 7'b111_1100;
      4'hC:    seg_o = 7'b011_1001;
      4'hD:    seg_o = 7'b101_1110;
      4'hE:    seg_o = 7'b111_1001;
      4'hF:    seg_o = 7'b111_0001;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment display controller. One decoder is shared by
// all digits; each digit is driven for DIGIT_CYCLES after BLANK_CYCLES of dark
// time. A loaded image waits in a pending register and is only committed when
// the scan wraps from the last digit back to digit 0, so a frame never mixes
// old and new contents. Outputs are registered from next-state values so that
// dig_en/seg/dp line up with the FSM state they describe.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 3,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_segment_scanner_if.slave  load_if,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_start
);

  localparam int CW = scan_cnt_width(DIGIT_CYCLES, BLANK_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         DIGIT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LAST  = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT_0   = NUM_DIGITS'(1);
  // Each digit slot starts with the dark gap unless the gap is disabled.
  localparam scan_state_e           DIGIT_ENTRY = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  // Scan sequencing
  scan_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             start_q;
  logic             boundary_s;

  // Load handshake and pending image
  logic             accept_s;
  logic             commit_s;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic [DW-1:0]          pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]  pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
  logic                   pend_lzs_q, pend_lzs_d;

  // Image currently on display
  logic [DW-1:0]          disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]  disp_blank_q, disp_blank_d;
  logic [NUM_DIGITS-1:0]  disp_dp_q, disp_dp_d;
  logic                   disp_lzs_q, disp_lzs_d;

  // Digit content path
  logic                   lzs_run_s;
  logic [NUM_DIGITS-1:0]  eff_blank_s;
  logic [3:0]             nibble_s;
  logic [6:0]             dec_seg_s;

  // Registered outputs
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]  dig_en_q, dig_en_d;
  logic                   frame_start_q, frame_start_d;

  // Scan state register; start_q marks the first edge after reset, which
  // opens the first frame so it gets a frame_start pulse like every other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      start_q <= 1'b0;
    end
  end

  // Next-state logic: dwell counting, digit advance and frame wrap detection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    boundary_s = 1'b0;
    if (start_q) begin
      state_d    = DIGIT_ENTRY;
      cnt_d      = '0;
      idx_d      = '0;
      boundary_s = 1'b1;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_DRIVE: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = DIGIT_ENTRY;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              boundary_s = 1'b1;
            end else begin
              idx_d      = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Handshake: capture on accept, release on commit. An accept on the
  // boundary edge itself wins over the (empty) commit and waits a frame.
  // Ready follows the registered pending flag, so it returns one cycle
  // after the commit edge.
  always_comb begin
    accept_s     = load_if.load_valid & ready_q;
    commit_s     = boundary_s & pending_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    pend_lzs_d   = pend_lzs_q;
    if (accept_s) begin
      pending_d    = 1'b1;
      pend_data_d  = load_if.load_data;
      pend_blank_d = load_if.load_blank;
      pend_dp_d    = load_if.load_dp;
      pend_lzs_d   = load_if.load_lzs;
    end else if (commit_s) begin
      pending_d    = 1'b0;
    end else begin
      pending_d    = pending_q;
    end
    ready_d = ~pending_q & ~accept_s;
  end

  // Display image for the upcoming cycle: swapped only at a frame wrap.
  always_comb begin
    if (commit_s) begin
      disp_data_d  = pend_data_q;
      disp_blank_d = pend_blank_q;
      disp_dp_d    = pend_dp_q;
      disp_lzs_d   = pend_lzs_q;
    end else begin
      disp_data_d  = disp_data_q;
      disp_blank_d = disp_blank_q;
      disp_dp_d    = disp_dp_q;
      disp_lzs_d   = disp_lzs_q;
    end
  end

  // Pending image and handshake registers; reset drops any queued load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      pend_lzs_q   <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      pend_lzs_q   <= pend_lzs_d;
    end
  end

  // Displayed image registers; after reset every digit is dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data_q  <= '0;
      disp_blank_q <= '1;
      disp_dp_q    <= '0;
      disp_lzs_q   <= 1'b0;
    end else begin
      disp_data_q  <= disp_data_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      disp_lzs_q   <= disp_lzs_d;
    end
  end

  // Effective blank mask: explicit blanks plus leading-zero suppression,
  // walking down from the top digit while every digit seen so far is zero.
  // Digit 0 is never suppressed; a lit decimal point exempts its digit.
  always_comb begin
    lzs_run_s   = 1'b1;
    eff_blank_s = disp_blank_d;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lzs_run_s      = lzs_run_s & (disp_data_d[4*i +: 4] == 4'h0);
      eff_blank_s[i] = disp_blank_d[i] | (disp_lzs_d & lzs_run_s & ~disp_dp_d[i]);
    end
  end

  assign nibble_s = disp_data_d[{idx_d, 2'b00} +: 4];

  seven_segment_scanner_decoder u_decoder (
    .nibble_i (nibble_s),
    .seg_o    (dec_seg_s)
  );

  // Pin values for the upcoming cycle, derived from the next scan state.
  always_comb begin
    seg_d         = SEG_OFF;
    dp_d          = 1'b0;
    dig_en_d      = '0;
    frame_start_d = boundary_s;
    if (state_d == S_DRIVE) begin
      dig_en_d = ONE_HOT_0 << idx_d;
      if (eff_blank_s[idx_d]) begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
      end else begin
        seg_d = dec_seg_s;
        dp_d  = disp_dp_d[idx_d];
      end
    end else begin
      seg_d    = SEG_OFF;
      dp_d     = 1'b0;
      dig_en_d = '0;
    end
  end

  // Output registers; reset darkens the display at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b0;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg                = seg_q;
  assign dp                 = dp_q;
  assign dig_en             = dig_en_q;
  assign frame_start        = frame_start_q;
  assign load_if.load_ready = ready_q;

endmodule
